// File: rtl/uart_rx_frame_parser_if.sv
// Bus bundle for the UART frame parser: byte input side, locked-frame output side
// and a debug view of the parser state.
//
// Handshakes: Rx_done is a valid-only strobe (Rx_byte qualified in the same cycle, no
// backpressure, ignored while En is low); Frm_valid is held until the consumer raises
// Frm_ack, and the frame is released on the first clock edge where both are high.
interface uart_rx_frame_parser_if;
   logic       En;
   logic [7:0] Rx_byte;
   logic       Rx_done;
   logic       Frm_ack;
   logic [3:0] Rd_addr;
   logic [7:0] Rd_data;
   logic [7:0] Frm_id;
   logic [4:0] Frm_len;
   logic       Frm_valid;
   logic       Frm_err;
   logic [1:0] Err_code;
   logic [7:0] Drop_cnt;
   logic [2:0] dbg_state;

   modport slave (
      input  En, Rx_byte, Rx_done, Frm_ack, Rd_addr,
      output Rd_data, Frm_id, Frm_len, Frm_valid, Frm_err, Err_code, Drop_cnt, dbg_state
   );

   modport master (
      output En, Rx_byte, Rx_done, Frm_ack, Rd_addr,
      input  Rd_data, Frm_id, Frm_len, Frm_valid, Frm_err, Err_code, Drop_cnt, dbg_state
   );
endinterface

// File: rtl/uart_rx_frame_parser.sv
// Parses AA 55 ID LEN payload CHK frames from a UART byte stream into a payload buffer
// and holds a good frame locked until the consumer acknowledges it.
module uart_rx_frame_parser #(
   parameter int unsigned TIMEOUT_CYC = 50000,
   parameter int unsigned MAX_LEN     = 16
) (
   input  logic                   CLK,
   input  logic                   RSTn,
   uart_rx_frame_parser_if.slave  bus
);

   // The buffer is addressed by the 4-bit Rd_addr, so MAX_LEN must not exceed 16.
   localparam int unsigned TO_W      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [7:0] MAX_LEN_B  = 8'(MAX_LEN);
   localparam logic [7:0] SYNC1      = 8'hAA;
   localparam logic [7:0] SYNC2      = 8'h55;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_HDR2    = 3'd1,
      S_ID      = 3'd2,
      S_LEN     = 3'd3,
      S_PAYLOAD = 3'd4,
      S_CHK     = 3'd5,
      S_LOCK    = 3'd6
   } state_t;

   state_t          state_q, state_d;
   logic [7:0]      id_q, id_d;
   logic [4:0]      len_q, len_d;
   logic [4:0]      idx_q, idx_d;
   logic [7:0]      sum_q, sum_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            err_q, err_d;
   logic [1:0]      err_code_q, err_code_d;
   logic [7:0]      drop_q, drop_d;

   logic [7:0]      buf_q [16];
   logic            buf_we;
   logic [3:0]      buf_waddr;
   logic [7:0]      buf_wdata;

   logic            rx_acc;
   logic            counting;
   logic            timeout;

   assign rx_acc   = bus.En & bus.Rx_done;
   assign counting = (state_q == S_HDR2) || (state_q == S_ID) || (state_q == S_LEN) ||
                     (state_q == S_PAYLOAD) || (state_q == S_CHK);
   assign timeout  = counting && (to_cnt_q == TO_MAX);

   // Counter runs only while a frame is in flight; any accepted byte restarts it.
   always_comb begin
      to_cnt_d = to_cnt_q;
      if (!counting || rx_acc || timeout) begin
         to_cnt_d = '0;
      end else begin
         to_cnt_d = to_cnt_q + TO_W'(1);
      end
   end

   always_comb begin
      state_d    = state_q;
      id_d       = id_q;
      len_d      = len_q;
      idx_d      = idx_q;
      sum_d      = sum_q;
      err_d      = 1'b0;
      err_code_d = err_code_q;
      drop_d     = drop_q;
      buf_we     = 1'b0;
      buf_waddr  = idx_q[3:0];
      buf_wdata  = bus.Rx_byte;

      if (timeout) begin
         state_d    = S_IDLE;
         err_d      = 1'b1;
         err_code_d = 2'd3;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (rx_acc && (bus.Rx_byte == SYNC1)) begin
                  state_d = S_HDR2;
               end
            end

            S_HDR2: begin
               if (rx_acc) begin
                  if (bus.Rx_byte == SYNC2) begin
                     state_d = S_ID;
                  end else if (bus.Rx_byte != SYNC1) begin
                     state_d = S_IDLE;
                  end
               end
            end

            S_ID: begin
               if (rx_acc) begin
                  id_d    = bus.Rx_byte;
                  sum_d   = bus.Rx_byte;
                  state_d = S_LEN;
               end
            end

            S_LEN: begin
               if (rx_acc) begin
                  if (bus.Rx_byte > MAX_LEN_B) begin
                     state_d    = S_IDLE;
                     err_d      = 1'b1;
                     err_code_d = 2'd2;
                  end else begin
                     len_d   = bus.Rx_byte[4:0];
                     sum_d   = sum_q + bus.Rx_byte;
                     idx_d   = 5'd0;
                     state_d = (bus.Rx_byte == 8'd0) ? S_CHK : S_PAYLOAD;
                  end
               end
            end

            S_PAYLOAD: begin
               if (rx_acc) begin
                  buf_we = 1'b1;
                  sum_d  = sum_q + bus.Rx_byte;
                  idx_d  = idx_q + 5'd1;
                  if ((idx_q + 5'd1) == len_q) begin
                     state_d = S_CHK;
                  end
               end
            end

            S_CHK: begin
               if (rx_acc) begin
                  if (bus.Rx_byte == sum_q) begin
                     state_d = S_LOCK;
                  end else begin
                     state_d    = S_IDLE;
                     err_d      = 1'b1;
                     err_code_d = 2'd1;
                  end
               end
            end

            S_LOCK: begin
               // Bytes arriving while locked, including in the ack cycle, are counted and lost.
               if (rx_acc && (drop_q != 8'hFF)) begin
                  drop_d = drop_q + 8'd1;
               end
               if (bus.Frm_ack) begin
                  state_d = S_IDLE;
               end
            end

            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q    <= S_IDLE;
         id_q       <= 8'd0;
         len_q      <= 5'd0;
         idx_q      <= 5'd0;
         sum_q      <= 8'd0;
         to_cnt_q   <= '0;
         err_q      <= 1'b0;
         err_code_q <= 2'd0;
         drop_q     <= 8'd0;
      end else begin
         state_q    <= state_d;
         id_q       <= id_d;
         len_q      <= len_d;
         idx_q      <= idx_d;
         sum_q      <= sum_d;
         to_cnt_q   <= to_cnt_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
         drop_q     <= drop_d;
      end
   end

   // Payload storage deliberately survives reset; stale bytes stay readable.
   always_ff @(posedge CLK) begin
      if (buf_we) begin
         buf_q[buf_waddr] <= buf_wdata;
      end
   end

   assign bus.Rd_data   = buf_q[bus.Rd_addr];
   assign bus.Frm_id    = id_q;
   assign bus.Frm_len   = len_q;
   assign bus.Frm_valid = (state_q == S_LOCK);
   assign bus.Frm_err   = err_q;
   assign bus.Err_code  = err_code_q;
   assign bus.Drop_cnt  = drop_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Directed bench for uart_rx_frame_parser: byte driver tasks, a scoreboard queue of
// expected frame/error events and a monitor that checks each event as it appears.
`timescale 1ns/100ps
module tb_uart_rx_frame_parser;
   localparam int T_CYC = 40;
   localparam int M_LEN = 16;
   localparam int W     = 273;
   localparam logic [1:0] K_VALID = 2'd1;
   localparam logic [1:0] K_ERR   = 2'd2;

   logic CLK = 1'b0;
   logic RSTn;
   uart_rx_frame_parser_if bus();

   uart_rx_frame_parser #(.TIMEOUT_CYC(T_CYC), .MAX_LEN(M_LEN)) dut (
      .CLK  (CLK),
      .RSTn (RSTn),
      .bus  (bus)
   );

   // ---------------- clock / reset ----------------
   always #5 CLK = ~CLK;

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q [$];
   logic [7:0]   tx_q  [$];
   logic [7:0]   mbuf  [16];
   logic         mknown[16];
   int           n_tests = 0;
   int           n_fail  = 0;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic mark(input int i, input logic [7:0] v);
      mbuf[i]   = v;
      mknown[i] = 1'b1;
   endtask

   task automatic push_valid(input logic [7:0] id, input logic [4:0] len);
      logic [127:0] b;
      logic [127:0] m;
      for (int i = 0; i < 16; i++) begin
         b[i*8 +: 8] = mknown[i] ? mbuf[i] : 8'h00;
         m[i*8 +: 8] = mknown[i] ? 8'hFF : 8'h00;
      end
      exp_q.push_back({K_VALID, 2'd0, id, len, b, m});
   endtask

   task automatic push_err(input logic [1:0] code);
      exp_q.push_back({K_ERR, code, 8'd0, 5'd0, 128'd0, 128'd0});
   endtask

   // ---------------- driver tasks ----------------
   task automatic send_byte(input logic [7:0] b);
      @(negedge CLK);
      bus.Rx_byte = b;
      bus.Rx_done = 1'b1;
      @(negedge CLK);
      bus.Rx_done = 1'b0;
   endtask

   task automatic send_q();
      foreach (tx_q[i]) send_byte(tx_q[i]);
   endtask

   task automatic ack();
      @(negedge CLK);
      bus.Frm_ack = 1'b1;
      @(negedge CLK);
      bus.Frm_ack = 1'b0;
      check("valid_low_after_ack", bus.Frm_valid, 0);
   endtask

   // ---------------- monitor ----------------
   initial begin : monitor
      logic         prev_v;
      logic [W-1:0] e;
      logic [127:0] rd;
      logic [127:0] eb;
      logic [127:0] em;
      prev_v = 1'b0;
      forever begin
         @(negedge CLK);
         if (!RSTn) begin
            prev_v = 1'b0;
         end else begin
            if (bus.Frm_err) begin
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_err: got code %0d expected no event at %0t", bus.Err_code, $time);
               end else begin
                  e = exp_q.pop_front();
                  check("err_event_kind", K_ERR, e[272:271]);
                  check("err_code", bus.Err_code, e[270:269]);
               end
            end
            if (bus.Frm_valid && !prev_v) begin
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_valid: got id %0h expected no event at %0t", bus.Frm_id, $time);
               end else begin
                  e = exp_q.pop_front();
                  check("valid_event_kind", K_VALID, e[272:271]);
                  check("frm_id", bus.Frm_id, e[268:261]);
                  check("frm_len", bus.Frm_len, e[260:256]);
                  for (int i = 0; i < 16; i++) begin
                     bus.Rd_addr = 4'(i);
                     #0.2;
                     rd[i*8 +: 8] = bus.Rd_data;
                  end
                  eb = e[255:128];
                  em = e[127:0];
                  check("payload_buf", rd & em, eb & em);
               end
            end
            prev_v = bus.Frm_valid;
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test expected finish before %0t", $time);
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin : stim
      logic [7:0] s;
      logic [7:0] p;
      RSTn        = 1'b0;
      bus.En      = 1'b1;
      bus.Rx_byte = 8'd0;
      bus.Rx_done = 1'b0;
      bus.Frm_ack = 1'b0;
      bus.Rd_addr = 4'd0;
      for (int i = 0; i < 16; i++) begin
         mbuf[i]   = 8'h00;
         mknown[i] = 1'b0;
      end

      repeat (3) @(negedge CLK);
      check("rst_state", bus.dbg_state, 3'd0);
      check("rst_valid", bus.Frm_valid, 0);
      check("rst_err", bus.Frm_err, 0);
      check("rst_err_code", bus.Err_code, 0);
      check("rst_id", bus.Frm_id, 0);
      check("rst_len", bus.Frm_len, 0);
      check("rst_drop", bus.Drop_cnt, 0);
      RSTn = 1'b1;
      repeat (2) @(negedge CLK);

      // good frame, one-cycle latency, then locked drops
      mark(0, 8'h10); mark(1, 8'h20);
      push_valid(8'h01, 5'd2);
      tx_q = '{8'hAA, 8'h55, 8'h01, 8'h02, 8'h10, 8'h20};
      send_q();
      check("valid_before_chk", bus.Frm_valid, 0);
      send_byte(8'h33);
      check("valid_latency", bus.Frm_valid, 1);
      tx_q = '{8'hAA, 8'h55, 8'h01};
      send_q();
      check("drop_cnt_3", bus.Drop_cnt, 8'd3);
      check("lock_valid", bus.Frm_valid, 1);
      check("lock_id", bus.Frm_id, 8'h01);
      check("lock_len", bus.Frm_len, 5'd2);
      bus.Rd_addr = 4'd0; #1;
      check("lock_buf0", bus.Rd_data, 8'h10);
      bus.Rd_addr = 4'd1; #1;
      check("lock_buf1", bus.Rd_data, 8'h20);
      ack();

      // bad checksum
      push_err(2'd1);
      tx_q = '{8'hAA, 8'h55, 8'h01, 8'h02, 8'h10, 8'h20, 8'h34};
      send_q();
      check("chk_err_pulse", bus.Frm_err, 1);
      check("chk_state_idle", bus.dbg_state, 3'd0);
      @(negedge CLK);
      check("chk_err_one_cycle", bus.Frm_err, 0);
      check("chk_err_code_held", bus.Err_code, 2'd1);
      check("chk_valid_low", bus.Frm_valid, 0);

      // oversize length then zero-length frame
      push_err(2'd2);
      tx_q = '{8'hAA, 8'h55, 8'h05, 8'h11};
      send_q();
      push_valid(8'h07, 5'd0);
      tx_q = '{8'hAA, 8'h55, 8'h07, 8'h00, 8'h07};
      send_q();
      check("len0_valid", bus.Frm_valid, 1);
      ack();

      // resync on repeated AA, and a leading junk byte
      push_valid(8'h03, 5'd0);
      tx_q = '{8'hAA, 8'hAA, 8'h55, 8'h03, 8'h00, 8'h03};
      send_q();
      ack();
      mark(0, 8'h09);
      push_valid(8'h04, 5'd1);
      tx_q = '{8'h12, 8'hAA, 8'h55, 8'h04, 8'h01, 8'h09, 8'h0E};
      send_q();
      ack();

      // checksum wrap-around: F0+02+80+90 = 0x202 -> 0x02
      mark(0, 8'h80); mark(1, 8'h90);
      push_valid(8'hF0, 5'd2);
      tx_q = '{8'hAA, 8'h55, 8'hF0, 8'h02, 8'h80, 8'h90, 8'h02};
      send_q();
      ack();

      // maximum length frame, then drop counter saturation while locked
      s = 8'h5A + 8'h10;
      tx_q = '{8'hAA, 8'h55, 8'h5A, 8'h10};
      for (int i = 0; i < 16; i++) begin
         p = 8'(i * 17 + 3);
         mark(i, p);
         s = s + p;
         tx_q.push_back(p);
      end
      tx_q.push_back(s);
      push_valid(8'h5A, 5'd16);
      send_q();
      check("maxlen_valid", bus.Frm_valid, 1);
      for (int i = 0; i < 260; i++) send_byte(8'hAA);
      check("drop_saturate", bus.Drop_cnt, 8'd255);
      check("sat_len_held", bus.Frm_len, 5'd16);
      ack();

      // inter-byte timeout, exact cycle
      push_err(2'd3);
      tx_q = '{8'hAA, 8'h55, 8'h01};
      send_q();
      repeat (T_CYC - 1) @(negedge CLK);
      check("to_not_early", bus.Frm_err, 0);
      @(negedge CLK);
      check("to_pulse", bus.Frm_err, 1);
      check("to_code", bus.Err_code, 2'd3);

      // En low mid-frame freezes state, timeout still fires
      push_err(2'd3);
      tx_q = '{8'hAA, 8'h55};
      send_q();
      bus.En = 1'b0;
      tx_q = '{8'h01, 8'h02};
      send_q();
      check("en_low_frozen", bus.dbg_state, 3'd2);
      repeat (T_CYC) @(negedge CLK);
      bus.En = 1'b1;
      check("en_low_idle", bus.dbg_state, 3'd0);
      push_valid(8'h03, 5'd0);
      tx_q = '{8'hAA, 8'h55, 8'h03, 8'h00, 8'h03};
      send_q();
      ack();

      // reset mid-frame: no error, registers cleared, buffer kept
      mark(0, 8'h10);
      tx_q = '{8'hAA, 8'h55, 8'h01, 8'h02, 8'h10};
      send_q();
      RSTn = 1'b0;
      @(negedge CLK);
      check("midrst_state", bus.dbg_state, 3'd0);
      check("midrst_drop", bus.Drop_cnt, 0);
      check("midrst_id", bus.Frm_id, 0);
      RSTn = 1'b1;
      bus.Rd_addr = 4'd0; #1;
      check("midrst_buf0", bus.Rd_data, mbuf[0]);
      bus.Rd_addr = 4'd5; #1;
      check("midrst_buf5", bus.Rd_data, mbuf[5]);
      repeat (T_CYC + 5) @(negedge CLK);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_frame_parser.md
UART_RX_FRAME_PARSER -- requirements
Module: uart_rx_frame_parser

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 50000, inter-byte timeout in CLK cycles (1 ms at 50 MHz).
REQ-002 SHALL have parameter MAX_LEN, default 16, maximum payload bytes per frame.
REQ-003 SHALL have port CLK  input  1  system clock, 50 MHz.
REQ-004 SHALL have port RSTn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port En  input  1  parser enable; when low, Rx_done is ignored.
REQ-006 SHALL have port Rx_byte  input  8  received byte from the UART receive controller.
REQ-007 SHALL have port Rx_done  input  1  one-cycle pulse; Rx_byte is valid in the same cycle.
REQ-008 SHALL have port Frm_ack  input  1  consumer releases the locked frame.
REQ-009 SHALL have port Rd_addr  input  4  payload buffer read address.
REQ-010 SHALL have port Rd_data  output  8  payload byte at Rd_addr, combinational read.
REQ-011 SHALL have port Frm_id  output  8  ID byte of the locked frame.
REQ-012 SHALL have port Frm_len  output  5  payload length of the locked frame.
REQ-013 SHALL have port Frm_valid  output  1  high while a good frame is locked.
REQ-014 SHALL have port Frm_err  output  1  one-cycle error pulse.
REQ-015 SHALL have port Err_code  output  2  cause of the last error: 1 checksum, 2 length, 3 timeout.
REQ-016 SHALL have port Drop_cnt  output  8  bytes dropped while locked; saturates at 255.

Function
REQ-017 Frame format SHALL be 0xAA, 0x55, ID, LEN, payload[LEN], CHK; CHK = (ID + LEN + sum of payload) mod 256.
REQ-018 States SHALL be IDLE, HDR2, ID, LEN, PAYLOAD, CHK and LOCK; transitions occur only on a Rx_done cycle with En high, except timeout and ack.
REQ-019 IDLE: byte 0xAA -> HDR2; any other byte stays in IDLE with no error.
REQ-020 HDR2: 0x55 -> ID; 0xAA stays in HDR2; any other byte -> IDLE with no error.
REQ-021 ID: stores the byte, starts the running sum, -> LEN.
REQ-022 LEN: if the value is > MAX_LEN -> IDLE, pulse Frm_err, Err_code=2; 0 -> CHK; otherwise -> PAYLOAD.
REQ-023 PAYLOAD: writes buf[idx] and increments idx; after LEN bytes -> CHK.
REQ-024 CHK: on match -> LOCK, with Frm_valid asserted the next cycle; on mismatch -> IDLE, pulse Frm_err, Err_code=1.
REQ-025 LOCK: Frm_valid, Frm_id, Frm_len and the buffer are held stable, and Rx_done bytes are discarded with Drop_cnt incremented.
REQ-026 LOCK: on Frm_ack -> IDLE, Frm_valid low the next cycle; a Rx_done in the same cycle as Frm_ack is dropped.
REQ-027 Timeout counter SHALL clear on every accepted Rx_done and count in states HDR2..CHK.
REQ-028 Timeout: on reaching TIMEOUT_CYC-1 -> IDLE, pulse Frm_err, Err_code=3; a simultaneous Rx_done is ignored.
REQ-029 Latency from Rx_done of a good CHK byte to Frm_valid high SHALL be 1 cycle.
REQ-030 Checksum arithmetic SHALL be 8-bit wrap-around.
REQ-031 Rd_addr >= Frm_len SHALL return the stale buffer contents, with no error raised.
REQ-032 En low mid-frame SHALL freeze the state but not the timeout counter, so the frame ends in a timeout.

Reset
REQ-033 While RSTn is low: state IDLE, Frm_valid=0, Frm_err=0, Err_code=0, Frm_id=0, Frm_len=0, Drop_cnt=0, idx=0, sum=0, timeout counter 0.
REQ-034 Reset SHALL NOT clear the buffer contents.
REQ-035 Reset asserted mid-frame SHALL abandon the frame with no Frm_err pulse.

Verification
REQ-036 Good frame: AA 55 01 02 10 20 33 -> Frm_valid=1 one cycle after the last byte; Frm_id=0x01, Frm_len=2, buf[0]=0x10, buf[1]=0x20.
REQ-037 Bad checksum: AA 55 01 02 10 20 34 -> one Frm_err pulse, Err_code=1, Frm_valid stays 0, state back to IDLE.
REQ-038 Oversize length: AA 55 05 11 -> Frm_err pulse with Err_code=2; the following AA 55 07 00 07 is accepted with Frm_len=0.
REQ-039 Resync: AA AA 55 03 00 03 -> valid frame with Frm_id=0x03; 12 AA 55 ... -> leading 0x12 ignored.
REQ-040 Timeout: AA 55 01 then no Rx_done for TIMEOUT_CYC cycles -> Frm_err pulse with Err_code=3.
REQ-041 Lock/drop: 3 bytes sent while Frm_valid is high -> Drop_cnt=3 and frame data unchanged; after Frm_ack, Frm_valid=0 the next cycle.
